fwu_port_arb: RTL and testbench
===============================

FWU_PORT_ARB -- requirements
Module: fwu_port_arb

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of host command ports, legal 1..8.
REQ-002 SHALL have parameter RSP_TIMEOUT, default 1_000_000, response watchdog limit in clk cycles, legal 1..2^32-1.
REQ-003 SHALL have ports clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have host-side command ports p_cmd_valid/p_cmd_ready/p_cmd_data_valid/p_cmd_data_ready/p_cmd_end  in/out/in/out/in  NUM_PORTS  per-port command handshakes, one bit per port.
REQ-005 SHALL have p_cmd_type  in  8*NUM_PORTS; p_cmd_seq  in  16*NUM_PORTS; p_cmd_len  in  16*NUM_PORTS; p_cmd_data  in  8*NUM_PORTS. Port i occupies slice i.
REQ-006 SHALL have engine-side e_cmd_valid/type/seq/len/data/data_valid/end  out  1/8/16/16/8/1/1, and e_cmd_ready/e_cmd_data_ready  in  1.
REQ-007 SHALL have engine response e_rsp_valid/type/seq/len/data/data_valid/end  in  1/8/16/16/8/1/1, and e_rsp_ready/e_rsp_data_ready  out  1.
REQ-008 SHALL have p_rsp_valid/p_rsp_data_valid/p_rsp_end  out  NUM_PORTS; p_rsp_ready/p_rsp_data_ready  in  NUM_PORTS; p_rsp_type/seq/len/data  out  8/16/16/8 (shared, broadcast to all ports).
REQ-009 SHALL have grant  out  max(1,$clog2(NUM_PORTS)) owning port; busy  out  1 grant held; drop_inc  out  1 one-cycle pulse; timeout_count  out  16 saturating watchdog count.

Function
REQ-010 SHALL implement states IDLE, CMD, RSP.
REQ-011 IDLE: if any p_cmd_valid, SHALL register grant = first requesting port at or after rr_ptr (circular), then enter CMD on the next cycle; no ready is asserted in IDLE.
REQ-012 CMD: granted port's command signals SHALL pass combinationally to e_cmd_*, and e_cmd_ready/e_cmd_data_ready return only to that port; all other p_cmd_ready/p_cmd_data_ready SHALL be 0.
REQ-013 Command frame complete = header handshake with len==0, or data-beat handshake with end=1; on completion, CMD SHALL go to RSP, or to IDLE if the response already completed (REQ-015).
REQ-014 RSP: e_rsp_* SHALL route to the granted port only (its p_rsp_valid/p_rsp_data_valid/p_rsp_end); e_rsp_ready/e_rsp_data_ready SHALL follow that port's ready bits.
REQ-015 Response routing SHALL also be active in CMD (early engine error reply); a response-complete flag SHALL be set for the granted transaction.
REQ-016 Response frame complete = header handshake with len==0, or data-beat handshake with end=1; on completion in RSP, SHALL go to IDLE and set rr_ptr = grant+1 mod NUM_PORTS.
REQ-017 In IDLE, e_rsp_ready and e_rsp_data_ready SHALL be 1 (unsolicited traffic discarded); each discarded header handshake SHALL pulse drop_inc for one cycle.
REQ-018 busy SHALL be 1 in CMD and RSP, 0 in IDLE; grant SHALL hold its value until the next arbitration.
REQ-019 NUM_PORTS==1 SHALL yield grant constantly 0 with identical state behaviour.
REQ-020 A port's p_cmd_valid dropping while granted in CMD before the header handshake SHALL not release the grant.

Reset
REQ-021 rst SHALL asynchronously force: state IDLE, rr_ptr 0, grant 0, busy 0, drop_inc 0, timeout_count 0, response-complete flag 0, watchdog counter 0.
REQ-022 Reset asserted mid-frame SHALL abandon the transaction; after release, the first arbitration SHALL start at port 0.

Configuration
REQ-023 Macro FWU_PORT_ARB_TIMEOUT_EN defined: 32-bit counter clears on RSP entry and counts each RSP cycle until the response header handshakes; reaching RSP_TIMEOUT SHALL force IDLE, advance rr_ptr, and increment timeout_count (saturate at 16'hFFFF).
REQ-024 Macro undefined: no counter; RSP waits indefinitely; timeout_count SHALL be tied to 0.

Verification
REQ-025 NUM_PORTS=2, both ports request in the same cycle after reset -> port 0 granted, then port 1 after the port 0 response completes; port 0 re-requests -> granted after port 1.
REQ-026 Port 1 sends type 0x10, seq 0x0005, len 3, data A1 A2 A3 (end on A3); engine replies len 0 -> e_cmd_* replicates the bytes in order; p_rsp_valid[1] only; back to IDLE.
REQ-027 Engine replies len 0 during CMD after byte 1 -> routed to the granted port; after end byte, state goes directly to IDLE (no RSP).
REQ-028 e_rsp_valid with len 0 in IDLE -> e_rsp_ready=1, drop_inc pulses exactly once, no p_rsp_valid.
REQ-029 With FWU_PORT_ARB_TIMEOUT_EN, RSP_TIMEOUT=16, engine silent -> IDLE exactly 16 cycles after RSP entry, timeout_count=1; without the macro -> still RSP after 100 cycles.
REQ-030 rst pulsed while in CMD with 2 bytes forwarded -> outputs reset immediately; next request from ports 0 and 1 grants port 0.

Source files
------------

// File: rtl/fwu_port_arb.sv
// fwu_port_arb
// Shares a single firmware-update engine among NUM_PORTS host command ports.
// The arbiter is idle until a host asks for the engine. It then picks one port
// round-robin and lets that port send one complete command frame. It then
// routes the engine's response frame back to that port alone and frees up.
//
// Optional feature (compile-time macro FWU_PORT_ARB_TIMEOUT_EN):
//   Adds a response watchdog. If the engine stays silent for RSP_TIMEOUT cycles
//   after the command completes, the transaction is abandoned and
//   timeout_count is bumped. Without the macro the arbiter waits forever for
//   the response and timeout_count reads 0.
//
// Ports
//   clk, rst               sole clock, asynchronous active-high reset
//   p_cmd_*                per-port command header + data-beat handshakes
//                          (bit i / slice i belongs to port i)
//   e_cmd_*                command stream forwarded to the engine
//   e_rsp_*                response stream coming back from the engine
//   p_rsp_*                per-port response valids/readies; payload fields
//                          are broadcast to every port
//   grant                  index of the port owning the engine
//   busy                   high while a transaction holds the grant
//   drop_inc               one-cycle pulse per discarded unsolicited header
//   timeout_count          saturating count of watchdog expiries
module fwu_port_arb #(
  parameter int          NUM_PORTS   = 2,
  parameter int unsigned RSP_TIMEOUT = 1_000_000,
  localparam int         GW          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  // host command side
  input  logic [NUM_PORTS-1:0]    p_cmd_valid,
  output logic [NUM_PORTS-1:0]    p_cmd_ready,
  input  logic [NUM_PORTS-1:0]    p_cmd_data_valid,
  output logic [NUM_PORTS-1:0]    p_cmd_data_ready,
  input  logic [NUM_PORTS-1:0]    p_cmd_end,
  input  logic [8*NUM_PORTS-1:0]  p_cmd_type,
  input  logic [16*NUM_PORTS-1:0] p_cmd_seq,
  input  logic [16*NUM_PORTS-1:0] p_cmd_len,
  input  logic [8*NUM_PORTS-1:0]  p_cmd_data,
  // engine command side
  output logic                   e_cmd_valid,
  input  logic                   e_cmd_ready,
  output logic [7:0]             e_cmd_type,
  output logic [15:0]            e_cmd_seq,
  output logic [15:0]            e_cmd_len,
  output logic [7:0]             e_cmd_data,
  output logic                   e_cmd_data_valid,
  input  logic                   e_cmd_data_ready,
  output logic                   e_cmd_end,
  // engine response side
  input  logic                   e_rsp_valid,
  output logic                   e_rsp_ready,
  input  logic [7:0]             e_rsp_type,
  input  logic [15:0]            e_rsp_seq,
  input  logic [15:0]            e_rsp_len,
  input  logic [7:0]             e_rsp_data,
  input  logic                   e_rsp_data_valid,
  output logic                   e_rsp_data_ready,
  input  logic                   e_rsp_end,
  // host response side
  output logic [NUM_PORTS-1:0]    p_rsp_valid,
  input  logic [NUM_PORTS-1:0]    p_rsp_ready,
  output logic [NUM_PORTS-1:0]    p_rsp_data_valid,
  input  logic [NUM_PORTS-1:0]    p_rsp_data_ready,
  output logic [NUM_PORTS-1:0]    p_rsp_end,
  output logic [7:0]             p_rsp_type,
  output logic [15:0]            p_rsp_seq,
  output logic [15:0]            p_rsp_len,
  output logic [7:0]             p_rsp_data,
  // status
  output logic [GW-1:0]          grant,
  output logic                   busy,
  output logic                   drop_inc,
  output logic [15:0]            timeout_count
);

  typedef enum logic [1:0] {IDLE, CMD, RSP} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant_q, rr_ptr, arb_pick, next_ptr;
  int            arb_idx;
  logic          any_req;
  logic          rsp_done_q, rsp_hdr_q, drop_q;

  // fields of the granted port
  logic          g_cmd_valid, g_cmd_data_valid, g_cmd_end;
  logic [7:0]    g_cmd_type, g_cmd_data;
  logic [15:0]   g_cmd_seq, g_cmd_len;
  logic          g_rsp_ready, g_rsp_data_ready;

  logic          routed;
  logic          cmd_hdr_hs, cmd_beat_end, cmd_done;
  logic          rsp_hdr_hs, rsp_beat_end, rsp_done_now;
  logic          timeout_hit;

  // Select the granted port's command fields and response readies.
  always_comb begin
    g_cmd_valid      = 1'b0;
    g_cmd_data_valid = 1'b0;
    g_cmd_end        = 1'b0;
    g_cmd_type       = '0;
    g_cmd_seq        = '0;
    g_cmd_len        = '0;
    g_cmd_data       = '0;
    g_rsp_ready      = 1'b0;
    g_rsp_data_ready = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == GW'(i)) begin
        g_cmd_valid      = p_cmd_valid[i];
        g_cmd_data_valid = p_cmd_data_valid[i];
        g_cmd_end        = p_cmd_end[i];
        g_cmd_type       = p_cmd_type[i*8 +: 8];
        g_cmd_seq        = p_cmd_seq[i*16 +: 16];
        g_cmd_len        = p_cmd_len[i*16 +: 16];
        g_cmd_data       = p_cmd_data[i*8 +: 8];
        g_rsp_ready      = p_rsp_ready[i];
        g_rsp_data_ready = p_rsp_data_ready[i];
      end
    end
  end

  // Round-robin pick: scan offsets from the far end down so the requester
  // closest to rr_ptr (circularly) is the last, winning assignment.
  always_comb begin
    arb_pick = '0;
    arb_idx  = 0;
    any_req  = |p_cmd_valid;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      arb_idx = (int'(rr_ptr) + k) % NUM_PORTS;
      if (p_cmd_valid[arb_idx]) begin
        arb_pick = GW'(arb_idx);
      end
    end
  end

  assign next_ptr = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

  // Responses are routed to the owner in CMD too, so an early engine error
  // reply can reach the host before the command frame finishes.
  assign routed       = (state != IDLE);
  assign cmd_hdr_hs   = e_cmd_valid & e_cmd_ready;
  assign cmd_beat_end = e_cmd_data_valid & e_cmd_data_ready & e_cmd_end;
  assign cmd_done     = (cmd_hdr_hs & (e_cmd_len == 16'd0)) | cmd_beat_end;
  assign rsp_hdr_hs   = routed & e_rsp_valid & g_rsp_ready;
  assign rsp_beat_end = routed & e_rsp_data_valid & g_rsp_data_ready & e_rsp_end;
  assign rsp_done_now = (rsp_hdr_hs & (e_rsp_len == 16'd0)) | rsp_beat_end;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (any_req) state_nxt = CMD;
      CMD: begin
        if (cmd_done) begin
          state_nxt = (rsp_done_q | rsp_done_now) ? IDLE : RSP;
        end
      end
      RSP: if (rsp_done_now | timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output routing. In IDLE the response side is held ready so stray engine
  // traffic drains instead of stalling the engine.
  always_comb begin
    p_cmd_ready      = '0;
    p_cmd_data_ready = '0;
    p_rsp_valid      = '0;
    p_rsp_data_valid = '0;
    p_rsp_end        = '0;
    e_cmd_valid      = 1'b0;
    e_cmd_data_valid = 1'b0;
    e_cmd_end        = 1'b0;
    e_cmd_type       = g_cmd_type;
    e_cmd_seq        = g_cmd_seq;
    e_cmd_len        = g_cmd_len;
    e_cmd_data       = g_cmd_data;
    e_rsp_ready      = 1'b1;
    e_rsp_data_ready = 1'b1;
    if (state == CMD) begin
      e_cmd_valid      = g_cmd_valid;
      e_cmd_data_valid = g_cmd_data_valid;
      e_cmd_end        = g_cmd_end;
    end
    if (routed) begin
      e_rsp_ready      = g_rsp_ready;
      e_rsp_data_ready = g_rsp_data_ready;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == GW'(i)) begin
        p_cmd_ready[i]      = (state == CMD) & e_cmd_ready;
        p_cmd_data_ready[i] = (state == CMD) & e_cmd_data_ready;
        p_rsp_valid[i]      = routed & e_rsp_valid;
        p_rsp_data_valid[i] = routed & e_rsp_data_valid;
        p_rsp_end[i]        = routed & e_rsp_end;
      end
    end
  end

  assign p_rsp_type = e_rsp_type;
  assign p_rsp_seq  = e_rsp_seq;
  assign p_rsp_len  = e_rsp_len;
  assign p_rsp_data = e_rsp_data;

  // Transaction bookkeeping: grant capture, round-robin pointer, and flags
  // remembering response progress made while the command was still running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q    <= '0;
      rr_ptr     <= '0;
      rsp_done_q <= 1'b0;
      rsp_hdr_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= (state == IDLE) & e_rsp_valid;
      if (state == IDLE) begin
        rsp_done_q <= 1'b0;
        rsp_hdr_q  <= 1'b0;
        if (any_req) begin
          grant_q <= arb_pick;
        end
      end else begin
        if (rsp_done_now) rsp_done_q <= 1'b1;
        if (rsp_hdr_hs)   rsp_hdr_q  <= 1'b1;
        if (state_nxt == IDLE) begin
          rr_ptr <= next_ptr;
        end
      end
    end
  end

`ifdef FWU_PORT_ARB_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(RSP_TIMEOUT - 1);

  logic [31:0] wd_cnt;
  logic [15:0] to_cnt;

  // The counter idles at zero outside RSP, so it starts fresh on every RSP
  // entry, and it freezes once the response header has been accepted.
  assign timeout_hit = (state == RSP) & ~rsp_hdr_q & ~rsp_hdr_hs & (wd_cnt == WD_LAST);

  // Response watchdog and its saturating expiry counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      to_cnt <= '0;
    end else begin
      if (state != RSP) begin
        wd_cnt <= '0;
      end else if (!rsp_hdr_q && !rsp_hdr_hs) begin
        wd_cnt <= wd_cnt + 32'd1;
      end
      if (timeout_hit && (to_cnt != 16'hFFFF)) begin
        to_cnt <= to_cnt + 16'd1;
      end
    end
  end

  assign timeout_count = to_cnt;
`else
  assign timeout_hit   = 1'b0;
  assign timeout_count = '0;
`endif

  assign grant    = grant_q;
  assign busy     = (state != IDLE);
  assign drop_inc = drop_q;

endmodule

// File: tb/tb_fwu_port_arb.sv
// tb_fwu_port_arb
// Scenario bench for fwu_port_arb with two ports and a 16-cycle watchdog limit.
// The expected owner of each transaction comes from a round-robin pointer
// model (the next port after the last served one, in circular order). The
// expected routing comes from the one-hot of that owner.
module tb_fwu_port_arb;
  localparam int N  = 2;
  localparam int TW = 8 * N;
  localparam int SW = 16 * N;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]  p_cmd_valid, p_cmd_ready, p_cmd_data_valid, p_cmd_data_ready, p_cmd_end;
  logic [TW-1:0] p_cmd_type, p_cmd_data;
  logic [SW-1:0] p_cmd_seq, p_cmd_len;
  logic          e_cmd_valid, e_cmd_ready, e_cmd_data_valid, e_cmd_data_ready, e_cmd_end;
  logic [7:0]    e_cmd_type, e_cmd_data;
  logic [15:0]   e_cmd_seq, e_cmd_len;
  logic          e_rsp_valid, e_rsp_ready, e_rsp_data_valid, e_rsp_data_ready, e_rsp_end;
  logic [7:0]    e_rsp_type, e_rsp_data;
  logic [15:0]   e_rsp_seq, e_rsp_len;
  logic [N-1:0]  p_rsp_valid, p_rsp_ready, p_rsp_data_valid, p_rsp_data_ready, p_rsp_end;
  logic [7:0]    p_rsp_type, p_rsp_data;
  logic [15:0]   p_rsp_seq, p_rsp_len;
  logic [0:0]    grant;
  logic          busy, drop_inc;
  logic [15:0]   timeout_count;

  int checks = 0;
  int passes = 0;
  int model_rr = 0;

  fwu_port_arb #(.NUM_PORTS(N), .RSP_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .p_cmd_valid(p_cmd_valid), .p_cmd_ready(p_cmd_ready),
    .p_cmd_data_valid(p_cmd_data_valid), .p_cmd_data_ready(p_cmd_data_ready),
    .p_cmd_end(p_cmd_end), .p_cmd_type(p_cmd_type), .p_cmd_seq(p_cmd_seq),
    .p_cmd_len(p_cmd_len), .p_cmd_data(p_cmd_data),
    .e_cmd_valid(e_cmd_valid), .e_cmd_ready(e_cmd_ready), .e_cmd_type(e_cmd_type),
    .e_cmd_seq(e_cmd_seq), .e_cmd_len(e_cmd_len), .e_cmd_data(e_cmd_data),
    .e_cmd_data_valid(e_cmd_data_valid), .e_cmd_data_ready(e_cmd_data_ready),
    .e_cmd_end(e_cmd_end),
    .e_rsp_valid(e_rsp_valid), .e_rsp_ready(e_rsp_ready), .e_rsp_type(e_rsp_type),
    .e_rsp_seq(e_rsp_seq), .e_rsp_len(e_rsp_len), .e_rsp_data(e_rsp_data),
    .e_rsp_data_valid(e_rsp_data_valid), .e_rsp_data_ready(e_rsp_data_ready),
    .e_rsp_end(e_rsp_end),
    .p_rsp_valid(p_rsp_valid), .p_rsp_ready(p_rsp_ready),
    .p_rsp_data_valid(p_rsp_data_valid), .p_rsp_data_ready(p_rsp_data_ready),
    .p_rsp_end(p_rsp_end), .p_rsp_type(p_rsp_type), .p_rsp_seq(p_rsp_seq),
    .p_rsp_len(p_rsp_len), .p_rsp_data(p_rsp_data),
    .grant(grant), .busy(busy), .drop_inc(drop_inc), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  // Safety net against a hung run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "[TB] simulation hung");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p_cmd_valid = '0; p_cmd_data_valid = '0; p_cmd_end = '0;
    p_cmd_type = '0; p_cmd_seq = '0; p_cmd_len = '0; p_cmd_data = '0;
    e_cmd_ready = 1'b0; e_cmd_data_ready = 1'b0;
    e_rsp_valid = 1'b0; e_rsp_data_valid = 1'b0; e_rsp_end = 1'b0;
    e_rsp_type = '0; e_rsp_seq = '0; e_rsp_len = '0; e_rsp_data = '0;
    p_rsp_ready = '0; p_rsp_data_ready = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    model_rr = 0;
  endtask

  // Reference arbitration: first requester at or after the model pointer.
  function automatic int model_pick(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(model_rr + k) % N]) return (model_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic arbitrate(input logic [N-1:0] mask, output int g);
    g = model_pick(mask);
    p_cmd_valid = mask;
    tick();
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL arb_busy: got %0b expected 1", busy); else passes++;
    checks++;
    if (grant !== 1'(g)) $display("[TB] FAIL arb_grant: got %0d expected %0d", grant, g); else passes++;
  endtask

  task automatic send_hdr(input int p, input logic [7:0] typ, input logic [15:0] seq, input logic [15:0] len);
    p_cmd_type = TW'($urandom);
    p_cmd_seq  = SW'($urandom);
    p_cmd_len  = SW'($urandom);
    p_cmd_type[p*8 +: 8]  = typ;
    p_cmd_seq[p*16 +: 16] = seq;
    p_cmd_len[p*16 +: 16] = len;
    p_cmd_valid[p] = 1'b1;
    e_cmd_ready = 1'b1;
    #1;
    checks++;
    if (e_cmd_valid !== 1'b1) $display("[TB] FAIL hdr_valid: got %0b expected 1", e_cmd_valid); else passes++;
    checks++;
    if ({e_cmd_type, e_cmd_seq, e_cmd_len} !== {typ, seq, len})
      $display("[TB] FAIL hdr_fields: got %h/%h/%h expected %h/%h/%h", e_cmd_type, e_cmd_seq, e_cmd_len, typ, seq, len);
    else passes++;
    checks++;
    if (p_cmd_ready !== (N'(1) << p)) $display("[TB] FAIL hdr_ready: got %b expected %b", p_cmd_ready, N'(1) << p); else passes++;
    tick();
    p_cmd_valid[p] = 1'b0;
    e_cmd_ready = 1'b0;
  endtask

  task automatic send_beat(input int p, input logic [7:0] b, input logic last);
    p_cmd_data = TW'($urandom);
    p_cmd_data[p*8 +: 8] = b;
    p_cmd_data_valid = N'(1) << p;
    p_cmd_end = last ? (N'(1) << p) : '0;
    e_cmd_data_ready = 1'b1;
    #1;
    checks++;
    if ({e_cmd_data_valid, e_cmd_data, e_cmd_end} !== {1'b1, b, last})
      $display("[TB] FAIL beat: got v%0b d%h e%0b expected v1 d%h e%0b", e_cmd_data_valid, e_cmd_data, e_cmd_end, b, last);
    else passes++;
    checks++;
    if (p_cmd_data_ready !== (N'(1) << p)) $display("[TB] FAIL beat_ready: got %b expected %b", p_cmd_data_ready, N'(1) << p); else passes++;
    tick();
    p_cmd_data_valid = '0;
    p_cmd_end = '0;
    e_cmd_data_ready = 1'b0;
  endtask

  // Engine response to owner p: one stalled cycle (only other ports ready),
  // then the header handshake, then rlen data beats.
  task automatic get_rsp(input int p, input int rlen);
    logic [N-1:0] oh;
    oh = N'(1) << p;
    e_rsp_valid = 1'b1;
    e_rsp_type  = 8'($urandom);
    e_rsp_seq   = 16'($urandom);
    e_rsp_len   = 16'(rlen);
    p_rsp_ready = ~oh;
    #1;
    checks++;
    if (e_rsp_ready !== 1'b0) $display("[TB] FAIL rsp_ready_stall: got %0b expected 0", e_rsp_ready); else passes++;
    checks++;
    if (p_rsp_valid !== oh) $display("[TB] FAIL rsp_valid_route: got %b expected %b", p_rsp_valid, oh); else passes++;
    checks++;
    if (p_rsp_seq !== e_rsp_seq) $display("[TB] FAIL rsp_seq: got %h expected %h", p_rsp_seq, e_rsp_seq); else passes++;
    tick();
    p_rsp_ready = oh;
    #1;
    checks++;
    if (e_rsp_ready !== 1'b1) $display("[TB] FAIL rsp_ready: got %0b expected 1", e_rsp_ready); else passes++;
    tick();
    e_rsp_valid = 1'b0;
    p_rsp_ready = '0;
    for (int b = 0; b < rlen; b++) begin
      e_rsp_data_valid = 1'b1;
      e_rsp_data = 8'($urandom);
      e_rsp_end = (b == rlen - 1);
      p_rsp_data_ready = oh;
      #1;
      checks++;
      if ({p_rsp_data_valid, p_rsp_end, e_rsp_data_ready} !== {oh, (b == rlen - 1) ? oh : N'(0), 1'b1})
        $display("[TB] FAIL rsp_beat: got %b/%b/%0b expected %b/%b/1", p_rsp_data_valid, p_rsp_end, e_rsp_data_ready,
                 oh, (b == rlen - 1) ? oh : N'(0));
      else passes++;
      checks++;
      if (p_rsp_data !== e_rsp_data) $display("[TB] FAIL rsp_data: got %h expected %h", p_rsp_data, e_rsp_data); else passes++;
      tick();
    end
    e_rsp_data_valid = 1'b0;
    e_rsp_end = 1'b0;
    p_rsp_data_ready = '0;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL rsp_to_idle: got busy %0b expected 0", busy); else passes++;
    model_rr = (p + 1) % N;
  endtask

  task automatic test_reset();
    idle_inputs();
    p_cmd_valid = '1;
    rst = 1'b1;
    #2;
    checks++;
    if ({busy, grant, drop_inc} !== 3'b000) $display("[TB] FAIL reset_state: got busy%0b grant%0d drop%0b expected 0/0/0", busy, grant, drop_inc); else passes++;
    checks++;
    if (timeout_count !== 16'd0) $display("[TB] FAIL reset_timeouts: got %0d expected 0", timeout_count); else passes++;
    checks++;
    if ({e_cmd_valid, p_cmd_ready, e_rsp_ready} !== {1'b0, N'(0), 1'b1})
      $display("[TB] FAIL reset_outputs: got %0b/%b/%0b expected 0/00/1", e_cmd_valid, p_cmd_ready, e_rsp_ready);
    else passes++;
    do_reset();
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    arbitrate(2'b11, g);
    send_hdr(g, 8'h01, 16'h0001, 16'd0);
    get_rsp(g, 0);
    arbitrate(2'b11, g);
    send_hdr(g, 8'h02, 16'h0002, 16'd0);
    get_rsp(g, 0);
    arbitrate(2'b11, g);
    checks++;
    if (g !== 0) $display("[TB] FAIL rr_model_return: got %0d expected 0", g); else passes++;
    send_hdr(g, 8'h03, 16'h0003, 16'd0);
    get_rsp(g, 0);
  endtask

  task automatic test_frame();
    int g;
    do_reset();
    arbitrate(2'b10, g);
    send_hdr(1, 8'h10, 16'h0005, 16'd3);
    send_beat(1, 8'hA1, 1'b0);
    send_beat(1, 8'hA2, 1'b0);
    send_beat(1, 8'hA3, 1'b1);
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL frame_in_rsp: got busy %0b expected 1", busy); else passes++;
    get_rsp(1, 0);
  endtask

  task automatic test_early_reply();
    int g;
    do_reset();
    arbitrate(2'b01, g);
    // owner withdraws its request while another port asks; grant must stay
    p_cmd_valid = 2'b10;
    repeat (2) tick();
    checks++;
    if ({busy, grant} !== 2'b10) $display("[TB] FAIL hold_grant: got busy%0b grant%0d expected 1/0", busy, grant); else passes++;
    p_cmd_valid = 2'b00;
    send_hdr(0, 8'h20, 16'h0100, 16'd2);
    send_beat(0, 8'h5A, 1'b0);
    e_rsp_valid = 1'b1;
    e_rsp_len = 16'd0;
    p_rsp_ready = 2'b01;
    #1;
    checks++;
    if ({p_rsp_valid, e_rsp_ready} !== 3'b011) $display("[TB] FAIL early_route: got %b/%0b expected 01/1", p_rsp_valid, e_rsp_ready); else passes++;
    tick();
    e_rsp_valid = 1'b0;
    p_rsp_ready = '0;
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL early_still_cmd: got busy %0b expected 1", busy); else passes++;
    send_beat(0, 8'hA5, 1'b1);
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL early_to_idle: got busy %0b expected 0", busy); else passes++;
    tick();
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL early_no_rsp: got busy %0b expected 0", busy); else passes++;
    model_rr = 1;
  endtask

  task automatic test_drop();
    int pulses;
    do_reset();
    e_rsp_valid = 1'b1;
    e_rsp_len = 16'd0;
    #1;
    checks++;
    if ({e_rsp_ready, p_rsp_valid} !== 3'b100) $display("[TB] FAIL drop_ready: got %0b/%b expected 1/00", e_rsp_ready, p_rsp_valid); else passes++;
    tick();
    e_rsp_valid = 1'b0;
    pulses = int'(drop_inc);
    // a lone data beat is drained but is not a header, so it is not counted
    e_rsp_data_valid = 1'b1;
    e_rsp_end = 1'b1;
    #1;
    checks++;
    if ({e_rsp_data_ready, p_rsp_data_valid} !== 3'b100) $display("[TB] FAIL drop_data: got %0b/%b expected 1/00", e_rsp_data_ready, p_rsp_data_valid); else passes++;
    tick();
    e_rsp_data_valid = 1'b0;
    e_rsp_end = 1'b0;
    pulses += int'(drop_inc);
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses += int'(drop_inc);
    end
    checks++;
    if (pulses !== 1) $display("[TB] FAIL drop_pulses: got %0d expected 1", pulses); else passes++;
  endtask

  task automatic test_timeout();
    int g;
    int n;
    do_reset();
    arbitrate(2'b01, g);
    send_hdr(0, 8'h30, 16'h0030, 16'd0);
`ifdef FWU_PORT_ARB_TIMEOUT_EN
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 16) $display("[TB] FAIL timeout_cycles: got %0d expected 16", n); else passes++;
    checks++;
    if (timeout_count !== 16'd1) $display("[TB] FAIL timeout_count: got %0d expected 1", timeout_count); else passes++;
    model_rr = 1;
    arbitrate(2'b11, g);
    send_hdr(g, 8'h31, 16'h0031, 16'd0);
    get_rsp(g, 0);
`else
    n = 0;
    repeat (100) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL no_timeout: got busy %0b after %0d cycles expected 1", busy, n); else passes++;
    get_rsp(0, 0);
    checks++;
    if (timeout_count !== 16'd0) $display("[TB] FAIL timeout_tied: got %0d expected 0", timeout_count); else passes++;
`endif
  endtask

  task automatic test_reset_mid();
    int g;
    do_reset();
    arbitrate(2'b01, g);
    send_hdr(0, 8'h40, 16'h0040, 16'd0);
    get_rsp(0, 0);
    arbitrate(2'b10, g);
    send_hdr(1, 8'h41, 16'h0041, 16'd3);
    send_beat(1, 8'h11, 1'b0);
    send_beat(1, 8'h22, 1'b0);
    p_cmd_valid = 2'b11;
    p_cmd_data_valid = 2'b10;
    e_cmd_data_ready = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, grant, e_cmd_valid, e_cmd_data_valid, p_cmd_data_ready} !== 6'b000000)
      $display("[TB] FAIL midreset_async: got %0b/%0d/%0b/%0b/%b expected 0/0/0/0/00", busy, grant, e_cmd_valid, e_cmd_data_valid, p_cmd_data_ready);
    else passes++;
    p_cmd_data_valid = '0;
    e_cmd_data_ready = 1'b0;
    tick();
    rst = 1'b0;
    model_rr = 0;
    arbitrate(2'b11, g);
    send_hdr(g, 8'h42, 16'h0042, 16'd0);
    get_rsp(g, 0);
  endtask

  task automatic test_random();
    int g;
    int len;
    logic [N-1:0] mask;
    do_reset();
    for (int t = 0; t < 24; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      arbitrate(mask, g);
      len = $urandom_range(0, 4);
      send_hdr(g, 8'($urandom), 16'($urandom), 16'(len));
      for (int b = 0; b < len; b++) begin
        send_beat(g, 8'($urandom), b == len - 1);
      end
      get_rsp(g, $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_frame();
    test_early_reply();
    test_drop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
